sevseg_scan: RTL and testbench
==============================

# sevseg_scan

Time-multiplexed driver for the 8-digit seven-segment display; consumer of the stopwatch's `display` / `digit_enable` / `dp_enable` bus. It latches one 32-bit BCD word per frame and scans the eight digits one at a time, each with a blanking guard against ghosting. For each digit it decodes the BCD nibble to active-low segment and anode lines that drive the board pins directly.

## Interface
- `FREQ_HZ`, 100000000, clk frequency in Hz.
- `DIGIT_HZ`, 8000, per-digit slot rate; DWELL = FREQ_HZ/DIGIT_HZ cycles per digit slot (localparam).
- `BLANK_CYCLES`, 100, guard cycles at the start of each slot with all anodes off. Legal range is 1 ≤ BLANK_CYCLES < DWELL.
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `display`  in  32  eight BCD nibbles; nibble i (bits 4i+3:4i) feeds digit i.
- `digit_enable`  in  8  bit i=1 means digit i is lit.
- `dp_enable`  in  8  bit i=1 means the decimal point of digit i is lit (only when digit i is enabled).
- `anode`  out  8  active-low digit select; at most one bit low.
- `cathode`  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
- `frame_strobe`  out  1  one-cycle pulse marking a new frame latch.

## Operation
- Internal slot counter `cnt` runs 0..DWELL-1. Digit index `idx` runs 0..7. At cnt==DWELL-1, cnt wraps to 0 and idx increments; idx wraps from 7 to 0.
- Phase BLANK applies when cnt < BLANK_CYCLES: anode=8'hFF, cathode=8'hFF.
- Phase ON applies when cnt ≥ BLANK_CYCLES:
  - If shadow digit_enable[idx] is set: anode = ~(1<<idx), cathode = {~dp_shadow[idx], ~seg(nibble idx)}.
  - Otherwise: anode=8'hFF, cathode=8'hFF.
- Frame latch: on the edge where cnt==0 and idx==0, the shadow registers capture `display`, `digit_enable` and `dp_enable`, and frame_strobe is set high for that one cycle. Between latches, input changes are ignored (no tearing).
- Segment glyphs, active-high {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles 10–15 are blank (00) unless the hex feature is compiled in.
- Reset (any cycle, including mid-slot): cnt=0, idx=0, shadows=0, anode=8'hFF, cathode=8'hFF, frame_strobe=0.

## Timing
- All outputs are registered. The output after edge k reflects cnt/idx as they were before edge k.
- Edge 0 is the first rising edge with resetn=1. After edge k (k ≥ 0), the outputs reflect cnt = k mod DWELL and idx = (k div DWELL) mod 8.
- Frame period is 8·DWELL cycles. frame_strobe is high after edges 0, 8·DWELL, 16·DWELL, …
- Input-to-pin latency: an input sampled at a frame latch first appears at edge BLANK_CYCLES of that frame, for digit 0.
- Anode transitions always pass through all-FF for BLANK_CYCLES cycles; two anodes are never low in the same cycle.

## Configuration
- `SEVSEG_HEX_EN` defined: nibbles 10–15 render A=77, b=7C, C=39, d=5E, E=79, F=71 (active-high {g..a}).
- Not defined: nibbles 10–15 render blank. Anode behaviour is unchanged and the dp still follows dp_enable.

## Structure
- Package `sevseg_pkg` holds:
  - the glyph constants (SEG_0..SEG_F, SEG_BLANK);
  - NUM_DIGITS=8;
  - the phase enum {PH_BLANK, PH_ON}.
- One sub-module, `sevseg_decoder`: combinational nibble→7-bit active-high glyph, containing the SEVSEG_HEX_EN switch. The top module inverts the glyph and appends dp.

## Test plan
All tests use FREQ_HZ=1000, DIGIT_HZ=100 (DWELL=10) and BLANK_CYCLES=2.
- Reset: hold resetn=0 for 3 cycles -> anode=FF, cathode=FF, frame_strobe=0; after release, frame_strobe=1 after edge 0 only.
- Single digit: display=0x00000001, digit_enable=01, dp_enable=01 -> FF/FF after edges 0–1; anode=FE, cathode=79 after edges 2–9; anode=FF throughout edges 10–79.
- Full walk: display=0x87654321, digit_enable=FF, dp_enable=00 -> anode steps FE,FD,FB,…,7F with cathodes F9,A4,B0,99,92,82,F8,80; anode returns to FE after edge 82.
- Frame coherency: change display to 0x00000002 after edge 30 -> digit 0 still shows F9 during edges 2–9 of the current frame; shows A4 after edges 82–89; frame_strobe is high after edge 80.
- Hex nibble: display=0x0000000A, digit_enable=01 -> cathode=FF without SEVSEG_HEX_EN, 88 with it (edges 2–9).
- Mid-operation reset: assert resetn=0 at edge 45 (digit 4, ON phase) -> next output is FF/FF; after release, the scan restarts at digit 0 with frame_strobe after the first edge.

Source files
------------

// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment scan driver: glyphs, digit count, slot phase.
package sevseg_pkg;

    localparam int NUM_DIGITS = 8;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_t;

endpackage

// File: rtl/sevseg_decoder.sv
// BCD/hex nibble to active-high 7-segment glyph. Define SEVSEG_HEX_EN to render
// nibbles 10-15 as A,b,C,d,E,F; otherwise they are blank.
module sevseg_decoder
    import sevseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (nibble)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
`ifdef SEVSEG_HEX_EN
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            4'hF: glyph = SEG_F;
`else
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: glyph = SEG_BLANK;
`endif
        endcase
    end

endmodule

// File: rtl/sevseg_scan.sv
// Eight-digit multiplexed seven-segment driver with per-frame shadow latch and
// blanking guard at the start of every digit slot. Hex glyphs via SEVSEG_HEX_EN.
module sevseg_scan
    import sevseg_pkg::*;
#(
    parameter int FREQ_HZ      = 100000000,
    parameter int DIGIT_HZ     = 8000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] display,
    input  logic [7:0]  digit_enable,
    input  logic [7:0]  dp_enable,
    output logic [7:0]  anode,
    output logic [7:0]  cathode,
    output logic        frame_strobe
);

    localparam int DWELL = FREQ_HZ / DIGIT_HZ;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [31:0]      display_reg;
    logic [7:0]       den_reg;
    logic [7:0]       dp_reg;
    logic [7:0]       anode_reg, anode_next;
    logic [7:0]       cathode_reg, cathode_next;
    logic             strobe_reg;

    logic             frame_latch;
    phase_t           phase;
    logic             lit;
    logic [3:0]       nibbles [NUM_DIGITS];
    logic [3:0]       nibble_sel;
    logic [6:0]       glyph;

    assign frame_latch = (cnt_reg == '0) && (idx_reg == 3'd0);
    assign phase       = (int'(cnt_reg) < BLANK_CYCLES) ? PH_BLANK : PH_ON;
    assign lit         = (phase == PH_ON) && den_reg[idx_reg];

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        idx_next = idx_reg;
        if (cnt_reg == CNT_W'(DWELL - 1)) begin
            cnt_next = '0;
            idx_next = idx_reg + 3'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nibbles[gi]    = display_reg[4*gi +: 4];
            // Only the active slot's anode can go low, so two digits never overlap
            assign anode_next[gi] = ~(lit && (idx_reg == 3'(gi)));
        end
    endgenerate

    assign nibble_sel = nibbles[idx_reg];

    sevseg_decoder u_decoder (
        .nibble (nibble_sel),
        .glyph  (glyph)
    );

    assign cathode_next = lit ? {~dp_reg[idx_reg], ~glyph} : 8'hFF;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_reg     <= '0;
            idx_reg     <= 3'd0;
            display_reg <= '0;
            den_reg     <= '0;
            dp_reg      <= '0;
            anode_reg   <= 8'hFF;
            cathode_reg <= 8'hFF;
            strobe_reg  <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            anode_reg   <= anode_next;
            cathode_reg <= cathode_next;
            strobe_reg  <= frame_latch;
            if (frame_latch) begin
                display_reg <= display;
                den_reg     <= digit_enable;
                dp_reg      <= dp_enable;
            end
        end
    end

    assign anode        = anode_reg;
    assign cathode      = cathode_reg;
    assign frame_strobe = strobe_reg;

endmodule

// File: tb/tb_sevseg_scan.sv
// Directed bench for sevseg_scan with DWELL=10, BLANK_CYCLES=2.
module tb_sevseg_scan;

    localparam int FREQ_HZ  = 1000;
    localparam int DIGIT_HZ = 100;
    localparam int BLANK    = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] display = '0;
    logic [7:0]  digit_enable = '0;
    logic [7:0]  dp_enable = '0;
    logic [7:0]  anode;
    logic [7:0]  cathode;
    logic        frame_strobe;

    int errors = 0;
    int checks = 0;
    int k = -1;

    sevseg_scan #(
        .FREQ_HZ      (FREQ_HZ),
        .DIGIT_HZ     (DIGIT_HZ),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .display      (display),
        .digit_enable (digit_enable),
        .dp_enable    (dp_enable),
        .anode        (anode),
        .cathode      (cathode),
        .frame_strobe (frame_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] disp;
        logic [7:0]  den;
        logic [7:0]  dpen;
        int          edge_n;
        logic [7:0]  exp_an;
        logic [7:0]  exp_cat;
    } vec_t;

`ifdef SEVSEG_HEX_EN
    localparam logic [7:0] CAT_A = 8'h88;
    localparam logic [7:0] CAT_F_DP = 8'h0E;
`else
    localparam logic [7:0] CAT_A = 8'hFF;
    localparam logic [7:0] CAT_F_DP = 8'h7F;
`endif

    vec_t vecs [16];
    logic [7:0] walk_an  [8];
    logic [7:0] walk_cat [8];

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%02h want=%02h", name, k, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0b want=%0b", name, k, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        k = -1;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    initial begin
        vecs[0]  = '{32'h00000001, 8'h01, 8'h01, 0,  8'hFF, 8'hFF};
        vecs[1]  = '{32'h00000001, 8'h01, 8'h01, 1,  8'hFF, 8'hFF};
        vecs[2]  = '{32'h00000001, 8'h01, 8'h01, 2,  8'hFE, 8'h79};
        vecs[3]  = '{32'h00000001, 8'h01, 8'h01, 9,  8'hFE, 8'h79};
        vecs[4]  = '{32'h00000001, 8'h01, 8'h01, 10, 8'hFF, 8'hFF};
        vecs[5]  = '{32'h00000001, 8'h01, 8'h01, 12, 8'hFF, 8'hFF};
        vecs[6]  = '{32'h87654321, 8'hFF, 8'h00, 12, 8'hFD, 8'hA4};
        vecs[7]  = '{32'h87654321, 8'hFF, 8'h00, 35, 8'hF7, 8'h99};
        vecs[8]  = '{32'h87654321, 8'hFF, 8'h00, 79, 8'h7F, 8'h80};
        vecs[9]  = '{32'h87654321, 8'hFF, 8'h00, 80, 8'hFF, 8'hFF};
        vecs[10] = '{32'h0000000A, 8'h01, 8'h00, 5,  8'hFE, CAT_A};
        vecs[11] = '{32'h0000000F, 8'h01, 8'h01, 5,  8'hFE, CAT_F_DP};
        vecs[12] = '{32'h00000009, 8'h00, 8'h01, 5,  8'hFF, 8'hFF};
        vecs[13] = '{32'h00000009, 8'h01, 8'h00, 3,  8'hFE, 8'h90};
        vecs[14] = '{32'h70000000, 8'h80, 8'h80, 75, 8'h7F, 8'h78};
        vecs[15] = '{32'h00000000, 8'h01, 8'h00, 4,  8'hFE, 8'hC0};

        walk_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        walk_cat = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};

        // Reset state held for three cycles
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check8("reset_anode", anode, 8'hFF);
            check8("reset_cathode", cathode, 8'hFF);
            check1("reset_strobe", frame_strobe, 1'b0);
        end

        // Table vectors, each from a fresh reset
        for (int v = 0; v < 16; v++) begin
            display      = vecs[v].disp;
            digit_enable = vecs[v].den;
            dp_enable    = vecs[v].dpen;
            do_reset();
            run_to(vecs[v].edge_n);
            check8($sformatf("vec%0d_anode", v), anode, vecs[v].exp_an);
            check8($sformatf("vec%0d_cathode", v), cathode, vecs[v].exp_cat);
            $display("vec %0d disp=%08h en=%02h dp=%02h edge=%0d an=%02h cat=%02h",
                     v, vecs[v].disp, vecs[v].den, vecs[v].dpen, vecs[v].edge_n, anode, cathode);
        end

        // Single digit across a full frame, plus strobe placement
        display = 32'h00000001; digit_enable = 8'h01; dp_enable = 8'h01;
        do_reset();
        for (int e = 0; e <= 81; e++) begin
            tick();
            check1("single_strobe", frame_strobe, (e == 0 || e == 80));
            if (e < 2 || e >= 10) begin
                check8("single_anode_off", anode, 8'hFF);
            end else begin
                check8("single_anode_on", anode, 8'hFE);
                check8("single_cathode_on", cathode, 8'h79);
            end
        end
        $display("single digit frame done at edge %0d", k);

        // Full walk over all eight digits and back to digit 0
        display = 32'h87654321; digit_enable = 8'hFF; dp_enable = 8'h00;
        do_reset();
        for (int e = 0; e <= 89; e++) begin
            tick();
            if ((e % 10) < BLANK) begin
                check8("walk_blank_anode", anode, 8'hFF);
                check8("walk_blank_cathode", cathode, 8'hFF);
            end else begin
                check8("walk_anode", anode, walk_an[(e / 10) % 8]);
                check8("walk_cathode", cathode, walk_cat[(e / 10) % 8]);
            end
        end
        $display("full walk done at edge %0d an=%02h", k, anode);

        // Frame coherency: mid-frame input change waits for the next latch
        display = 32'h00000001; digit_enable = 8'h01; dp_enable = 8'h00;
        do_reset();
        run_to(2);
        check8("coh_cur_cathode", cathode, 8'hF9);
        run_to(9);
        check8("coh_cur_cathode_end", cathode, 8'hF9);
        run_to(30);
        display = 32'h00000002;
        run_to(79);
        check8("coh_gap_anode", anode, 8'hFF);
        tick();
        check1("coh_strobe80", frame_strobe, 1'b1);
        run_to(82);
        check8("coh_new_anode", anode, 8'hFE);
        check8("coh_new_cathode", cathode, 8'hA4);
        run_to(89);
        check8("coh_new_cathode_end", cathode, 8'hA4);
        $display("coherency: edge %0d cathode=%02h", k, cathode);

        // Mid-operation reset during digit 4 ON phase
        display = 32'h87654321; digit_enable = 8'hFF; dp_enable = 8'h00;
        do_reset();
        run_to(44);
        check8("mid_pre_anode", anode, 8'hEF);
        check8("mid_pre_cathode", cathode, 8'h92);
        resetn = 1'b0;
        tick();
        check8("mid_rst_anode", anode, 8'hFF);
        check8("mid_rst_cathode", cathode, 8'hFF);
        check1("mid_rst_strobe", frame_strobe, 1'b0);
        resetn = 1'b1;
        k = -1;
        tick();
        check1("mid_restart_strobe", frame_strobe, 1'b1);
        check8("mid_restart_anode", anode, 8'hFF);
        tick();
        check1("mid_restart_strobe1", frame_strobe, 1'b0);
        run_to(2);
        check8("mid_restart_d0_anode", anode, 8'hFE);
        check8("mid_restart_d0_cathode", cathode, 8'hF9);
        $display("mid reset restart: edge %0d an=%02h cat=%02h", k, anode, cathode);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
